// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one registered output channel among N valid/ready
// requesters; the winner's word is captured into a single-entry output register.
module rr_mux_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned W     = 8,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req_vld,
  input  logic [N*W-1:0]     req_data,
  output logic [N-1:0]       req_rdy,
  output logic               out_vld,
  output logic [W-1:0]       out_data,
  output logic [IDX_W-1:0]   out_src,
  input  logic               out_rdy
);

  localparam logic [IDX_W:0]   N_EXT = (IDX_W+1)'(N);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(N-1);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_nxt;
  logic [IDX_W:0]   scan_idx;
  logic [IDX_W-1:0] win_idx;
  logic             win_vld;
  logic             can_take;
  logic             take;
  logic [W-1:0]     sel_data;

  // Scan ptr, ptr+1, ... modulo N; one extra bit keeps the wrap exact for any N.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < int'(N); k++) begin
      scan_idx = {1'b0, ptr} + (IDX_W+1)'(k);
      if (scan_idx >= N_EXT) begin
        scan_idx = scan_idx - N_EXT;
      end
      if (!win_vld && req_vld[scan_idx[IDX_W-1:0]]) begin
        win_vld = 1'b1;
        win_idx = scan_idx[IDX_W-1:0];
      end
    end
  end

  assign can_take = !out_vld || out_rdy;
  assign take     = win_vld && can_take && !rst;
  assign ptr_nxt  = (win_idx == LAST) ? '0 : win_idx + IDX_W'(1);

  // One-hot ready and the data mux share the same decoded winner.
  always_comb begin
    req_rdy  = '0;
    sel_data = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (win_idx == IDX_W'(i)) begin
        sel_data   = req_data[i*W +: W];
        req_rdy[i] = take;
      end
    end
  end

  // Output register: refill on transfer, otherwise empty on drain, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_src  <= '0;
      ptr      <= '0;
    end else if (take) begin
      out_vld  <= 1'b1;
      out_data <= sel_data;
      out_src  <= win_idx;
      ptr      <= ptr_nxt;
    end else if (out_rdy) begin
      out_vld  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: directed vector table, corner sequences, and random
// traffic against a modulo-arithmetic reference model (N=4 and N=3 instances).
module tb_rr_mux_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  vld4;
  logic [31:0] data4;
  logic [3:0]  rdy4;
  logic        ovld4;
  logic [7:0]  odata4;
  logic [1:0]  osrc4;
  logic        ordy4;
  logic [2:0]  vld3;
  logic [23:0] data3;
  logic [2:0]  rdy3;
  logic        ovld3;
  logic [7:0]  odata3;
  logic [1:0]  osrc3;
  logic        ordy3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rr_mux_arbiter #(.N(4), .W(8)) dut4 (
    .clk(clk), .rst(rst), .req_vld(vld4), .req_data(data4), .req_rdy(rdy4),
    .out_vld(ovld4), .out_data(odata4), .out_src(osrc4), .out_rdy(ordy4)
  );

  rr_mux_arbiter #(.N(3), .W(8)) dut3 (
    .clk(clk), .rst(rst), .req_vld(vld3), .req_data(data3), .req_rdy(rdy3),
    .out_vld(ovld3), .out_data(odata3), .out_src(osrc3), .out_rdy(ordy3)
  );

  typedef struct {
    logic [3:0] vld;
    logic       ordy;
    logic [3:0] rdy;
    logic       ovld;
    logic [7:0] data;
    logic [1:0] src;
  } vec_t;

  typedef struct {
    bit vld;
    int data;
    int src;
    int ptr;
  } model_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int m_winner(input int n, input int ptr, input logic [3:0] vld);
    for (int k = 0; k < n; k++) begin
      if (vld[(ptr + k) % n]) return (ptr + k) % n;
    end
    return -1;
  endfunction

  function automatic logic [3:0] m_rdy(input model_t m, input int n, input logic [3:0] vld,
                                       input logic ordy);
    logic [3:0] r = 4'b0;
    int w = m_winner(n, m.ptr, vld);
    if ((!m.vld || ordy) && w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  function automatic model_t m_next(input model_t m, input int n, input logic [3:0] vld,
                                    input logic [31:0] data, input logic ordy);
    model_t r = m;
    int w = m_winner(n, m.ptr, vld);
    if ((!m.vld || ordy) && w >= 0) begin
      r.vld  = 1'b1;
      r.data = int'(data[w*8 +: 8]);
      r.src  = w;
      r.ptr  = (w + 1) % n;
    end else if (m.vld && ordy) begin
      r.vld = 1'b0;
    end
    return r;
  endfunction

  vec_t   vecs [17];
  model_t m4, m3;

  initial begin
    vecs[0]  = '{4'hF, 1'b1, 4'h1, 1'b1, 8'hA0, 2'd0};
    vecs[1]  = '{4'hF, 1'b1, 4'h2, 1'b1, 8'hA1, 2'd1};
    vecs[2]  = '{4'hF, 1'b1, 4'h4, 1'b1, 8'hA2, 2'd2};
    vecs[3]  = '{4'hF, 1'b1, 4'h8, 1'b1, 8'hA3, 2'd3};
    vecs[4]  = '{4'hF, 1'b1, 4'h1, 1'b1, 8'hA0, 2'd0};
    vecs[5]  = '{4'hF, 1'b1, 4'h2, 1'b1, 8'hA1, 2'd1};
    vecs[6]  = '{4'h1, 1'b1, 4'h1, 1'b1, 8'hA0, 2'd0};
    vecs[7]  = '{4'h6, 1'b0, 4'h0, 1'b1, 8'hA0, 2'd0};
    vecs[8]  = '{4'h6, 1'b0, 4'h0, 1'b1, 8'hA0, 2'd0};
    vecs[9]  = '{4'h6, 1'b0, 4'h0, 1'b1, 8'hA0, 2'd0};
    vecs[10] = '{4'h6, 1'b1, 4'h2, 1'b1, 8'hA1, 2'd1};
    vecs[11] = '{4'h8, 1'b1, 4'h8, 1'b1, 8'hA3, 2'd3};
    vecs[12] = '{4'hF, 1'b1, 4'h1, 1'b1, 8'hA0, 2'd0};
    vecs[13] = '{4'h0, 1'b1, 4'h0, 1'b0, 8'hA0, 2'd0};
    vecs[14] = '{4'h4, 1'b0, 4'h4, 1'b1, 8'hA2, 2'd2};
    vecs[15] = '{4'h4, 1'b0, 4'h0, 1'b1, 8'hA2, 2'd2};
    vecs[16] = '{4'h0, 1'b1, 4'h0, 1'b0, 8'hA2, 2'd2};

    // Reset held with every requester valid.
    rst   = 1'b1;
    vld4  = 4'hF;
    data4 = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    ordy4 = 1'b1;
    vld3  = 3'b0;
    data3 = {8'hC2, 8'hC1, 8'hC0};
    ordy3 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rdy", 32'(rdy4), 32'h0);
    chk("reset_vld", 32'(ovld4), 32'h0);
    chk("reset_data", 32'(odata4), 32'h0);
    chk("reset_src", 32'(osrc4), 32'h0);
    chk("reset_rdy3", 32'(rdy3), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Directed vectors: contention, backpressure, wrap, drain, stall.
    for (int i = 0; i < 17; i++) begin
      vld4  = vecs[i].vld;
      ordy4 = vecs[i].ordy;
      @(negedge clk);
      chk($sformatf("v%0d_rdy", i), 32'(rdy4), 32'(vecs[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_vld", i), 32'(ovld4), 32'(vecs[i].ovld));
      chk($sformatf("v%0d_data", i), 32'(odata4), 32'(vecs[i].data));
      chk($sformatf("v%0d_src", i), 32'(osrc4), 32'(vecs[i].src));
    end

    // Async reset between edges discards a held word.
    vld4  = 4'hF;
    ordy4 = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_areset_vld", 32'(ovld4), 32'h1);
    chk("pre_areset_src", 32'(osrc4), 32'h3);
    #2 rst = 1'b1;
    #1;
    chk("areset_vld", 32'(ovld4), 32'h0);
    chk("areset_rdy", 32'(rdy4), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    ordy4 = 1'b1;
    @(negedge clk);
    chk("post_areset_rdy", 32'(rdy4), 32'h1);
    @(posedge clk);
    #1;
    chk("post_areset_src", 32'(osrc4), 32'h0);
    chk("post_areset_data", 32'(odata4), 32'hA0);

    // Non-power-of-two rotation on the N=3 instance.
    vld4 = 4'h0;
    vld3 = 3'b111;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("n3_rdy%0d", i), 32'(rdy3), 32'(1 << (i % 3)));
      @(posedge clk);
      #1;
      chk($sformatf("n3_src%0d", i), 32'(osrc3), 32'(i % 3));
      chk($sformatf("n3_data%0d", i), 32'(odata3), 32'(8'hC0 + (i % 3)));
      chk($sformatf("n3_vld%0d", i), 32'(ovld3), 32'h1);
    end

    // Random traffic against the reference model.
    vld3 = 3'b0;
    rst  = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m4 = '{1'b0, 0, 0, 0};
    m3 = '{1'b0, 0, 0, 0};
    for (int i = 0; i < 400; i++) begin
      logic [3:0] e4, e3;
      vld4  = 4'($urandom_range(0, 15));
      data4 = $urandom;
      ordy4 = ($urandom_range(0, 3) != 0);
      vld3  = 3'($urandom_range(0, 7));
      data3 = 24'($urandom);
      ordy3 = ($urandom_range(0, 2) != 0);
      e4 = m_rdy(m4, 4, vld4, ordy4);
      e3 = m_rdy(m3, 3, {1'b0, vld3}, ordy3);
      @(negedge clk);
      chk($sformatf("r%0d_rdy4", i), 32'(rdy4), 32'(e4));
      chk($sformatf("r%0d_rdy3", i), 32'(rdy3), 32'(e3));
      @(posedge clk);
      m4 = m_next(m4, 4, vld4, data4, ordy4);
      m3 = m_next(m3, 3, {1'b0, vld3}, {8'h0, data3}, ordy3);
      #1;
      chk($sformatf("r%0d_vld4", i), 32'(ovld4), 32'(m4.vld));
      chk($sformatf("r%0d_vld3", i), 32'(ovld3), 32'(m3.vld));
      if (m4.vld) begin
        chk($sformatf("r%0d_data4", i), 32'(odata4), 32'(m4.data));
        chk($sformatf("r%0d_src4", i), 32'(osrc4), 32'(m4.src));
      end
      if (m3.vld) begin
        chk($sformatf("r%0d_data3", i), 32'(odata3), 32'(m3.data));
        chk($sformatf("r%0d_src3", i), 32'(osrc3), 32'(m3.src));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one output channel among N valid/ready requesters.
- Each cycle it computes a grant and drives the select of an N:1 data mux.
- It captures the winning word into a single-entry output register.
- It sits between several producer blocks and one shared consumer (bus, FIFO write port, or ALU input); it is the sequencing and sharing layer for our mux primitives.

Parameters:
- N, 4, number of requesters (N >= 2; need not be a power of two).
- W, 8, data width per requester.
- IDX_W, $clog2(N), width of the grant index (derived; not to be overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req_vld  input  N  per-requester valid; bit i belongs to requester i.
- req_data  input  N*W  packed data; requester i uses bits [i*W +: W].
- req_rdy  output  N  per-requester ready; at most one bit set (one-hot or zero).
- out_vld  output  1  output register holds a valid word.
- out_data  output  W  registered data word.
- out_src  output  IDX_W  index of the requester that produced out_data.
- out_rdy  input  1  consumer accepts out_data when out_vld && out_rdy.

Behaviour:
- Reset (async, rst=1): out_vld=0, out_data=0, out_src=0, priority pointer ptr=0. req_rdy=0 follows combinationally, since no grant is possible while rst is high.
- Accept condition: can_take = !out_vld || out_rdy. The output register is empty, or it is being drained this cycle.
- Winner selection (combinational): scan indices ptr, ptr+1, ..., ptr+N-1, each taken modulo N. The first i with req_vld[i]=1 wins.
  - Wrap must be correct for non-power-of-two N; e.g. N=3, ptr=2 scans 2,0,1.
- req_rdy[g]=1 only when can_take=1 and g is the winner. All other bits are 0, and all bits are 0 when no req_vld is set.
- Transfer from requester g occurs when req_vld[g] && req_rdy[g]. On that clock edge:
  - out_data <= req_data[g], out_src <= g, out_vld <= 1.
  - ptr <= (g+1) mod N, so g becomes lowest priority. g=N-1 wraps ptr to 0.
- Drain without refill (out_vld && out_rdy, no winner): out_vld <= 0. out_data and out_src hold their last values.
- Simultaneous drain and refill: the new word replaces the old one in the same edge, and out_vld stays 1. Sustained throughput is one word per clock.
- Stall (out_vld && !out_rdy): out_data, out_src and out_vld are held stable. No req_rdy is asserted, and ptr does not move.
- ptr changes only on a completed input transfer, never on requests alone.
- Latency: a word accepted at edge k appears on out_data after edge k (one cycle).
- Requester protocol: once raised, a requester must keep req_vld and req_data stable until req_rdy. The arbiter re-evaluates every cycle and does not depend on this rule for its own correctness.
- Fairness: with all N requesters continuously valid and out_rdy=1, grants rotate 0,1,...,N-1,0,...
  - Any continuously valid requester is granted within N accepted transfers.
- Reset mid-operation: a held output word is discarded (out_vld=0 immediately), and ptr returns to 0.
- No combinational path from req_data to out_data. The output is fully registered.
- req_rdy depends combinationally on req_vld, out_vld, out_rdy and ptr. A requester must not drive req_vld from req_rdy.

Test Plan:
- Reset: hold rst=1 with all req_vld=1 -> req_rdy=0, out_vld=0, out_data=0, out_src=0. After release with out_rdy=1, the first grant goes to requester 0.
- Full contention (N=4, W=8): data_i=8'hA0+i, all req_vld=1, out_rdy=1 -> out_src sequence is 0,1,2,3,0,1, one word per clock, out_data=A0,A1,A2,A3,A0.
- Backpressure: one word in the register, out_rdy=0 for 3 cycles, req_vld=4'b0110 -> req_rdy=0 throughout, and out_data/out_src/ptr stay stable. When out_rdy=1, requester 1 is accepted in that same cycle.
- Sparse/skip: ptr=2 (after a grant to 1), only req_vld[0]=1 -> requester 0 wins via wrap, then ptr=1. A single requester 3 wins, then ptr wraps to 0.
- Non-power-of-two: N=3, all requesters valid -> grants 0,1,2,0,1,2, and out_src never reaches 3.
- Async reset mid-stream: assert rst between clock edges while out_vld=1 -> out_vld drops before the next edge. After release, arbitration restarts at requester 0.
